// File: rtl/in_port_if.sv
// Producer/processor-side bundle of the input-port controller.
interface in_port_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  ext_data;
  logic          ext_valid;
  logic          ext_ready;
  logic          in_rd;
  logic          int_en;
  logic [W-1:0]  in_port;
  logic          interrupt;
  logic [CW-1:0] count;
  logic          underflow;

  modport master (
    output ext_data, ext_valid, in_rd, int_en,
    input  ext_ready, in_port, interrupt, count, underflow
  );

  modport slave (
    input  ext_data, ext_valid, in_rd, int_en,
    output ext_ready, in_port, interrupt, count, underflow
  );
endinterface

// File: rtl/in_port_ctrl.sv
// Input-port controller: buffers producer words in a FIFO for the processor's
// in_port and raises a one-cycle interrupt pulse (re-pulsed on timeout).
module in_port_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     rst,
  in_port_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE   = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          underflow;
  logic          interrupt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;

  logic nonempty_c;
  logic full_c;
  logic push_c;
  logic pop_c;
  logic tmr_max_c;

  assign nonempty_c = (count != '0);
  assign full_c     = (count == CW'(DEPTH));
  assign push_c     = bus.ext_valid & ~full_c;
  assign pop_c      = bus.in_rd & nonempty_c;
  assign tmr_max_c  = (tmr == TW'(TIMEOUT - 1));

  assign bus.ext_ready = ~full_c;
  assign bus.in_port   = nonempty_c ? mem[rp] : '0;
  assign bus.count     = count;
  assign bus.underflow = underflow;
  assign bus.interrupt = interrupt;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_c) mem[wp] <= bus.ext_data;
  end

  // Pointers, occupancy and sticky underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push_c) wp <= wp + AW'(1);
      if (pop_c)  rp <= rp + AW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (pop_c && !push_c) count <= count - CW'(1);
      if (bus.in_rd && !nonempty_c) underflow <= 1'b1;
    end
  end

  // Interrupt FSM state, timer and registered pulse output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tmr       <= '0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      interrupt <= (state_nxt == PULSE);
    end
  end

  // Next state; the timer only runs in SERVICE and restarts on every pop.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = '0;
    case (state)
      IDLE: begin
        if (bus.int_en && nonempty_c) state_nxt = PULSE;
      end
      PULSE: begin
        state_nxt = SERVICE;
      end
      SERVICE: begin
        if (!nonempty_c)                  state_nxt = IDLE;
        else if (bus.int_en && tmr_max_c) state_nxt = PULSE;
        if (!pop_c) tmr_nxt = tmr_max_c ? tmr : tmr + TW'(1);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed plus randomized bench for in_port_ctrl against a queue-based model.
module tb_in_port_ctrl;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned T     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  in_port_if #(.W(W), .DEPTH(DEPTH)) bus ();

  in_port_ctrl #(.W(W), .DEPTH(DEPTH), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_log[$];

  // Reference model: words waiting for the processor plus interrupt bookkeeping.
  logic [W-1:0] q[$];
  bit m_uf;
  bit m_pulse;
  bit m_servicing;
  int m_quiet;
  bit m_push;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    q.delete();
    m_uf        = 1'b0;
    m_pulse     = 1'b0;
    m_servicing = 1'b0;
    m_quiet     = 0;
    m_push      = 1'b0;
  endtask

  task automatic mdl_edge();
    int n;
    bit pop;
    bit nxt_pulse;
    if (!rst) begin
      mdl_reset();
      return;
    end
    n         = q.size();
    m_push    = bus.ext_valid && (n != DEPTH);
    pop       = bus.in_rd && (n != 0);
    nxt_pulse = 1'b0;
    if (bus.in_rd && n == 0) m_uf = 1'b1;
    if (m_pulse) begin
      m_servicing = 1'b1;
      m_quiet     = 0;
    end else if (m_servicing) begin
      if (n == 0) m_servicing = 1'b0;
      else if (bus.int_en && m_quiet == T - 1) begin
        nxt_pulse   = 1'b1;
        m_servicing = 1'b0;
      end
      m_quiet = pop ? 0 : ((m_quiet + 1 > T - 1) ? T - 1 : m_quiet + 1);
    end else if (bus.int_en && n != 0) begin
      nxt_pulse = 1'b1;
    end
    m_pulse = nxt_pulse;
    if (pop) void'(q.pop_front());
    if (m_push) q.push_back(bus.ext_data);
  endtask

  task automatic compare();
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("in_port", 32'(bus.in_port), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("ext_ready", 32'(bus.ext_ready), 32'(q.size() != DEPTH));
    chk("interrupt", 32'(bus.interrupt), 32'(m_pulse));
    chk("underflow", 32'(bus.underflow), 32'(m_uf));
  endtask

  task automatic step();
    @(posedge clk);
    mdl_edge();
    #1;
    cyc++;
    if (bus.interrupt === 1'b1) pulse_log.push_back(cyc);
    compare();
  endtask

  task automatic idle_inputs();
    bus.ext_valid = 1'b0;
    bus.ext_data  = '0;
    bus.in_rd     = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus.int_en = 1'b0;
    mdl_reset();

    // Reset then idle.
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (10) step();
    chk("rst_in_port", 32'(bus.in_port), 32'd0);

    // Single word with interrupt.
    bus.int_en    = 1'b1;
    bus.ext_valid = 1'b1;
    bus.ext_data  = 16'hA5A5;
    step();
    bus.ext_valid = 1'b0;
    chk("sw_data", 32'(bus.in_port), 32'h0000A5A5);
    pulse_log.delete();
    repeat (5) step();
    chk("sw_pulses", 32'(pulse_log.size()), 32'd1);
    bus.in_rd = 1'b1;
    step();
    bus.in_rd = 1'b0;
    chk("sw_empty", 32'(bus.in_port), 32'd0);
    repeat (3) step();

    // Fill, hold-off while full, and wrap.
    for (int i = 1; i <= 4; i++) begin
      bus.ext_valid = 1'b1;
      bus.ext_data  = 16'(i);
      step();
    end
    chk("full_ready", 32'(bus.ext_ready), 32'd0);
    chk("full_head", 32'(bus.in_port), 32'd1);
    bus.ext_data = 16'h0005;
    bus.in_rd    = 1'b1;
    step();
    bus.in_rd = 1'b0;
    chk("full_no_push", 32'(bus.count), 32'd3);
    step();
    bus.ext_valid = 1'b0;
    chk("late_push", 32'(bus.count), 32'd4);
    for (int i = 2; i <= 5; i++) begin
      chk("wrap_pop", 32'(bus.in_port), 32'(i));
      bus.in_rd = 1'b1;
      step();
      bus.in_rd = 1'b0;
    end
    chk("wrap_empty", 32'(bus.count), 32'd0);

    // Simultaneous push/pop at two entries, then push into empty with a read.
    idle_inputs();
    bus.ext_valid = 1'b1;
    bus.ext_data  = 16'h0011; step();
    bus.ext_data  = 16'h0022; step();
    bus.ext_data  = 16'h0033;
    bus.in_rd     = 1'b1;     step();
    chk("sim_count", 32'(bus.count), 32'd2);
    chk("sim_head", 32'(bus.in_port), 32'h22);
    bus.ext_valid = 1'b0;     step();
    chk("sim_order", 32'(bus.in_port), 32'h33);
    step();
    bus.ext_valid = 1'b1;
    bus.ext_data  = 16'h0044;
    step();
    idle_inputs();
    chk("uf_count", 32'(bus.count), 32'd1);
    chk("uf_flag", 32'(bus.underflow), 32'd1);
    chk("uf_data", 32'(bus.in_port), 32'h44);
    bus.in_rd = 1'b1; step(); bus.in_rd = 1'b0;
    repeat (3) step();

    // Timeout re-pulsing, then suppression by int_en.
    bus.ext_valid = 1'b1;
    bus.ext_data  = 16'h1234;
    step();
    bus.ext_valid = 1'b0;
    pulse_log.delete();
    repeat (40) step();
    chk("to_npulses", 32'(pulse_log.size()), 32'd5);
    for (int i = 1; i < pulse_log.size(); i++)
      chk("to_gap", 32'(pulse_log[i] - pulse_log[i-1]), 32'd9);
    bus.int_en = 1'b0;
    pulse_log.delete();
    repeat (30) step();
    chk("to_quiet", 32'(pulse_log.size()), 32'd0);
    chk("to_kept", 32'(bus.in_port), 32'h1234);
    bus.in_rd = 1'b1; step(); bus.in_rd = 1'b0;

    // Asynchronous reset mid-operation with three words in SERVICE.
    bus.int_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ext_valid = 1'b1;
      bus.ext_data  = 16'hB000 + 16'(i);
      step();
    end
    bus.ext_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    mdl_reset();
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_in_port", 32'(bus.in_port), 32'd0);
    chk("arst_interrupt", 32'(bus.interrupt), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Randomized traffic; the producer holds a word until it is taken.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.ext_valid || m_push) begin
        bus.ext_valid = ($urandom_range(0, 99) < 55);
        bus.ext_data  = 16'($urandom);
      end
      bus.in_rd = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 5) bus.int_en = ~bus.int_en;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
